// File: rtl/lwlr.sv
// lwlr: merge unit for MIPS32 big-endian unaligned loads (LWL / LWR).
//
// Merges the aligned memory word with the current rt value according to the
// address byte offset. Each result byte is picked by a 4:1 mux over the
// memory bytes or passed through from rt, so no 32-bit variable shifter is
// built. Every output byte always has a defined source.
//
// Optional feature macro: LWLR_REG_OUT_EN
//   defined   -> reg_write_data_q / valid_q are registered (1-cycle latency)
//   undefined -> reg_write_data_q / valid_q are combinational copies of
//                reg_write_data / en, and clk / rst_n are unused
//
// Ports:
//   clk              system clock, rising edge
//   rst_n            asynchronous active-low reset (registered path only)
//   reg_data_b       current rt value, source of the preserved bytes
//   data_readdata    aligned memory word read from address & ~3
//   byte_offset      effective address [1:0]
//   lwl              1 = LWL, 0 = LWR
//   en               a valid LWL/LWR is present this cycle
//   reg_write_data   merged result, combinational
//   reg_write_data_q registered (or pass-through) merged result
//   valid_q          registered (or pass-through) en
module lwlr (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] reg_data_b,
    input  logic [31:0] data_readdata,
    input  logic [1:0]  byte_offset,
    input  logic        lwl,
    input  logic        en,
    output logic [31:0] reg_write_data,
    output logic [31:0] reg_write_data_q,
    output logic        valid_q
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned LANES  = 4;

    // Per-lane merge: choose a memory byte or keep the rt byte.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        localparam logic [1:0] LANE = 2'(gi);

        logic       use_mem;
        logic [1:0] src;
        logic [7:0] mem_byte;
        logic [7:0] lane_byte;

        always_comb begin
            use_mem  = 1'b0;
            src      = 2'd0;
            mem_byte = data_readdata[7:0];
            // LWL shifts memory up by k lanes; LWR shifts it down by 3-k.
            // The 2-bit subtraction/addition only wraps on lanes that keep rt.
            if (lwl) begin
                use_mem = (LANE >= byte_offset);
                src     = LANE - byte_offset;
            end else begin
                use_mem = (LANE <= byte_offset);
                src     = LANE + 2'd3 - byte_offset;
            end
            case (src)
                2'd0:    mem_byte = data_readdata[7:0];
                2'd1:    mem_byte = data_readdata[15:8];
                2'd2:    mem_byte = data_readdata[23:16];
                default: mem_byte = data_readdata[31:24];
            endcase
            lane_byte = use_mem ? mem_byte : reg_data_b[8*gi +: 8];
        end

        assign reg_write_data[8*gi +: 8] = lane_byte;
    end

`ifdef LWLR_REG_OUT_EN
    logic [DATA_W-1:0] reg_write_data_d;
    logic              valid_d;

    // Capture the merged word only for a valid load; otherwise hold.
    always_comb begin
        reg_write_data_d = reg_write_data_q;
        valid_d          = en;
        if (en) begin
            reg_write_data_d = reg_write_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_write_data_q <= '0;
            valid_q          <= 1'b0;
        end else begin
            reg_write_data_q <= reg_write_data_d;
            valid_q          <= valid_d;
        end
    end
`else
    // No output stage: the registered ports mirror the combinational path.
    assign reg_write_data_q = reg_write_data;
    assign valid_q          = en;

    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;
`endif

endmodule

// File: tb/tb_lwlr.sv
module tb_lwlr;

    logic        clk;
    logic        rst_n;
    logic [31:0] reg_data_b;
    logic [31:0] data_readdata;
    logic [1:0]  byte_offset;
    logic        lwl;
    logic        en;
    logic [31:0] reg_write_data;
    logic [31:0] reg_write_data_q;
    logic        valid_q;

    int n_cmp;
    int n_bad;

    lwlr dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .reg_data_b       (reg_data_b),
        .data_readdata    (data_readdata),
        .byte_offset      (byte_offset),
        .lwl              (lwl),
        .en               (en),
        .reg_write_data   (reg_write_data),
        .reg_write_data_q (reg_write_data_q),
        .valid_q          (valid_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: the architectural shift-and-mask definition of LWL/LWR.
    function automatic logic [31:0] model(input logic [31:0] rt, input logic [31:0] mem,
                                          input logic [1:0] k, input logic is_lwl);
        int          n;
        logic [31:0] keep;
        n = 8 * int'(k);
        if (is_lwl) begin
            keep = (32'd1 << n) - 32'd1;
            return (mem << n) | (rt & keep);
        end else begin
            keep = ~(32'hFFFF_FFFF >> (24 - n));
            return (mem >> (24 - n)) | (rt & keep);
        end
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [31:0] rt, input logic [31:0] mem,
                         input logic [1:0] k, input logic l, input logic e);
        reg_data_b    = rt;
        data_readdata = mem;
        byte_offset   = k;
        lwl           = l;
        en            = e;
    endtask

    logic [31:0] exp_q;
    logic [31:0] exp_lwl [4];
    logic [31:0] exp_lwr [4];
    logic [31:0] rt_r;
    logic [31:0] mem_r;
    logic [1:0]  k_r;
    logic        l_r;
    logic        e_r;

    initial begin
        n_cmp = 0;
        n_bad = 0;
        exp_q = 32'h0;
        exp_lwl[0] = 32'h0011_2233; exp_lwl[1] = 32'h1122_33dd;
        exp_lwl[2] = 32'h2233_ccdd; exp_lwl[3] = 32'h33bb_ccdd;
        exp_lwr[0] = 32'haabb_cc00; exp_lwr[1] = 32'haabb_0011;
        exp_lwr[2] = 32'haa00_1122; exp_lwr[3] = 32'h0011_2233;

        rst_n = 1'b0;
        drive(32'haabb_ccdd, 32'h0011_2233, 2'd0, 1'b1, 1'b0);
        #2;
`ifdef LWLR_REG_OUT_EN
        check("reset_q", reg_write_data_q, 32'h0);
        check("reset_valid", 32'(valid_q), 32'h0);
`endif
        check("reset_comb_unaffected", reg_write_data, 32'h0011_2233);

        @(negedge clk);
        rst_n = 1'b1;

        // Directed offset sweep for both opcodes.
        for (int k = 0; k < 4; k++) begin
            for (int l = 0; l < 2; l++) begin
                @(negedge clk);
                drive(32'haabb_ccdd, 32'h0011_2233, 2'(k), 1'(l), 1'b0);
                #1;
                check($sformatf("dir_%s_k%0d", (l != 0) ? "lwl" : "lwr", k), reg_write_data,
                      (l != 0) ? exp_lwl[k] : exp_lwr[k]);
            end
        end

`ifdef LWLR_REG_OUT_EN
        // One-cycle capture then hold.
        @(negedge clk);
        drive(32'haabb_ccdd, 32'h0011_2233, 2'd1, 1'b1, 1'b1);
        @(posedge clk); #1;
        check("pulse_q", reg_write_data_q, 32'h1122_33dd);
        check("pulse_valid", 32'(valid_q), 32'h1);
        @(negedge clk);
        drive(32'h1234_5678, 32'h9abc_def0, 2'd2, 1'b0, 1'b0);
        @(posedge clk); #1;
        check("hold_q", reg_write_data_q, 32'h1122_33dd);
        check("hold_valid", 32'(valid_q), 32'h0);
        exp_q = 32'h1122_33dd;
`else
        // Pass-through tracks inputs without any clock edge.
        @(negedge clk);
        drive(32'haabb_ccdd, 32'h0011_2233, 2'd1, 1'b1, 1'b1);
        #1;
        check("pass_q", reg_write_data_q, 32'h1122_33dd);
        check("pass_valid", 32'(valid_q), 32'h1);
        en = 1'b0; byte_offset = 2'd2; lwl = 1'b0;
        #1;
        check("pass_q2", reg_write_data_q, 32'haa00_1122);
        check("pass_valid2", 32'(valid_q), 32'h0);
`endif

        // Random vectors against the reference model.
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            rt_r  = $urandom;
            mem_r = $urandom;
            k_r   = 2'($urandom_range(3, 0));
            l_r   = 1'($urandom_range(1, 0));
            e_r   = 1'($urandom_range(1, 0));
            drive(rt_r, mem_r, k_r, l_r, e_r);
            #1;
            check("rand_comb", reg_write_data, model(rt_r, mem_r, k_r, l_r));
`ifdef LWLR_REG_OUT_EN
            @(posedge clk); #1;
            if (e_r) exp_q = model(rt_r, mem_r, k_r, l_r);
            check("rand_q", reg_write_data_q, exp_q);
            check("rand_valid", 32'(valid_q), 32'(e_r));
`else
            check("rand_q", reg_write_data_q, model(rt_r, mem_r, k_r, l_r));
            check("rand_valid", 32'(valid_q), 32'(e_r));
`endif
        end

        // Reset asserted mid-operation with en high.
        @(negedge clk);
        drive(32'haabb_ccdd, 32'h0011_2233, 2'd3, 1'b1, 1'b1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
`ifdef LWLR_REG_OUT_EN
        check("midrst_q", reg_write_data_q, 32'h0);
        check("midrst_valid", 32'(valid_q), 32'h0);
        @(posedge clk); #1;
        check("midrst_hold_q", reg_write_data_q, 32'h0);
        check("midrst_hold_valid", 32'(valid_q), 32'h0);
`else
        check("midrst_q", reg_write_data_q, 32'h33bb_ccdd);
        check("midrst_valid", 32'(valid_q), 32'h1);
`endif
        check("midrst_comb", reg_write_data, 32'h33bb_ccdd);

        // Release and confirm capture resumes on the next edge.
        @(negedge clk);
        rst_n = 1'b1;
        drive(32'haabb_ccdd, 32'h0011_2233, 2'd0, 1'b0, 1'b1);
        @(posedge clk); #1;
        check("release_q", reg_write_data_q, 32'haabb_cc00);
        check("release_valid", 32'(valid_q), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
